// File: rtl/ad_resp_pkg.sv
// Shared definitions for the AD SPI responder: command codes, modes, FSM states and
// register reset defaults.
package ad_resp_pkg;

  localparam int          CHAN_W   = 4;
  localparam int          NCHAN    = 1 << CHAN_W;
  localparam logic [15:0] MASK_RST = 16'hFFFF;
  localparam logic [3:0]  LAST_RST = 4'hF;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO1  = 2'b01,
    MODE_AUTO2  = 2'b10
  } mode_e;

  typedef enum logic [3:0] {
    CMD_CONT       = 4'h0,
    CMD_MANUAL     = 4'h1,
    CMD_AUTO1      = 4'h2,
    CMD_AUTO2      = 4'h3,
    CMD_GPIO       = 4'h4,
    CMD_AUTO1_PROG = 4'h8,
    CMD_AUTO2_PROG = 4'h9,
    CMD_ALARM_PROG = 4'hD
  } cmd_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_e;

  // What the next complete frame carries instead of a command.
  typedef enum logic [1:0] {PEND_NONE, PEND_MASK, PEND_THR} pend_e;

endpackage

// File: rtl/ad_resp_seq.sv
// Channel sequencer: picks the channel for the next frame from the mode, the auto1 mask,
// the auto2 last channel and the channel currently selected.
module ad_resp_seq
  import ad_resp_pkg::*;
(
  input  mode_e              mode_i,
  input  logic               restart_i,
  input  logic [CHAN_W-1:0]  cur_i,
  input  logic [CHAN_W-1:0]  manual_i,
  input  logic [CHAN_W-1:0]  last_i,
  input  logic [NCHAN-1:0]   mask_i,
  output logic [CHAN_W-1:0]  next_o
);

  logic [CHAN_W-1:0] lowest, above;
  logic              found_low, found_above;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    lowest      = '0;
    above       = '0;
    found_low   = 1'b0;
    found_above = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (mask_i[i] && !found_low) begin
        lowest    = CHAN_W'(i);
        found_low = 1'b1;
      end
      if (mask_i[i] && !found_above && i > int'(cur_i)) begin
        above       = CHAN_W'(i);
        found_above = 1'b1;
      end
    end

    case (mode_i)
      MODE_AUTO1: next_o = (restart_i || !found_above) ? lowest : above;
      MODE_AUTO2: next_o = (restart_i || cur_i >= last_i) ? '0 : cur_i + CHAN_W'(1);
      default:    next_o = manual_i;
    endcase
  end

endmodule

// File: rtl/ad_spi_responder.sv
// SPI slave emulating a 16-channel SAR ADC; all SPI pins are oversampled in the CLK domain.
// Define AD_RESP_ALARM_EN to enable the sample-over-threshold Alarm output.
module ad_spi_responder
  import ad_resp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SDI,
  output logic              SDO,
  output logic              Smp_Req,
  output logic [3:0]        Smp_Chan,
  input  logic              Smp_Ack,
  input  logic [DATA_W-1:0] Smp_Data,
  output logic [1:0]        Mode,
  output logic [3:0]        GPIO_Out,
  output logic              Frame_Done,
  output logic              Err_Late,
  output logic              Alarm
);

  localparam int FRAME_W = CHAN_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
`ifdef AD_RESP_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sclk_s_q, cs_s_q, sdi_s_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, sdi_bit;

  // CS synchronisers reset high so leaving reset never looks like a frame start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_s_q <= '0;
      cs_s_q   <= '1;
      sdi_s_q  <= '0;
    end else begin
      sclk_s_q <= {sclk_s_q[SYNC_STAGES-2:0], SCLK};
      cs_s_q   <= {cs_s_q[SYNC_STAGES-2:0], CS};
      sdi_s_q  <= {sdi_s_q[SYNC_STAGES-2:0], SDI};
    end
  end

  assign sclk_rise =  sclk_s_q[SYNC_STAGES-2] & ~sclk_s_q[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_s_q[SYNC_STAGES-2] &  sclk_s_q[SYNC_STAGES-1];
  assign cs_rise   =  cs_s_q[SYNC_STAGES-2]   & ~cs_s_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s_q[SYNC_STAGES-2]   &  cs_s_q[SYNC_STAGES-1];
  assign sdi_bit   =  sdi_s_q[SYNC_STAGES-1];

  state_e             state_q;
  mode_e              mode_q, mode_d;
  pend_e              pend_q;
  logic [FRAME_W-1:0] out_q, cmd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CHAN_W-1:0]  chan_q, chan_d, seq_next, manual_q, manual_d, last_q, smp_chan_q;
  logic [NCHAN-1:0]   mask_q;
  logic [DATA_W-1:0]  thr_q;
  logic [3:0]         gpio_q, cmd_code;
  logic               sdo_q, req_q, done_q, late_q, alarm_q, seq_restart, hold_chan;

  assign cmd_code = cmd_q[FRAME_W-1 -: 4];

  // Decode of the frame just received; consumed and program frames hold the channel.
  always_comb begin
    mode_d      = mode_q;
    manual_d    = manual_q;
    seq_restart = 1'b0;
    hold_chan   = 1'b0;
    if (pend_q != PEND_NONE) begin
      hold_chan = 1'b1;
    end else begin
      case (cmd_code)
        CMD_MANUAL: begin
          mode_d = MODE_MANUAL;
          if (cmd_q[11]) manual_d = cmd_q[10:7];
        end
        CMD_AUTO1: if (cmd_q[11]) begin
          mode_d      = MODE_AUTO1;
          seq_restart = 1'b1;
        end
        CMD_AUTO2: if (cmd_q[11]) begin
          mode_d      = MODE_AUTO2;
          seq_restart = 1'b1;
        end
        CMD_AUTO1_PROG, CMD_AUTO2_PROG, CMD_ALARM_PROG: hold_chan = 1'b1;
        default: ;
      endcase
    end
  end

  ad_resp_seq u_seq (
    .mode_i    (mode_d),
    .restart_i (seq_restart),
    .cur_i     (chan_q),
    .manual_i  (manual_d),
    .last_i    (last_q),
    .mask_i    (mask_q),
    .next_o    (seq_next)
  );

  assign chan_d = hold_chan ? chan_q : seq_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_MANUAL;
      pend_q     <= PEND_NONE;
      out_q      <= '0;
      cmd_q      <= '0;
      cnt_q      <= '0;
      chan_q     <= '0;
      manual_q   <= '0;
      last_q     <= LAST_RST;
      mask_q     <= MASK_RST;
      thr_q      <= '1;
      gpio_q     <= '0;
      smp_chan_q <= '0;
      sdo_q      <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      late_q     <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later ones in this block win.
      done_q <= 1'b0;
      if (state_q == ST_LOAD && req_q && Smp_Ack) begin
        out_q[DATA_W-1:0] <= Smp_Data;
        req_q             <= 1'b0;
        alarm_q           <= Smp_Data > thr_q;
      end

      case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_q    <= ST_LOAD;
          out_q      <= {chan_q, {DATA_W{1'b0}}};
          sdo_q      <= chan_q[CHAN_W-1];
          req_q      <= 1'b1;
          smp_chan_q <= chan_q;
          cnt_q      <= '0;
        end
        ST_LOAD, ST_SHIFT: begin
          if (cs_rise) begin
            state_q <= ST_IDLE;
            sdo_q   <= 1'b0;
            req_q   <= 1'b0;
          end else begin
            if (sclk_fall && state_q == ST_SHIFT) begin
              out_q <= out_q << 1;
              sdo_q <= out_q[FRAME_W-2];
            end
            if (sclk_rise) begin
              cmd_q   <= {cmd_q[FRAME_W-2:0], sdi_bit};
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ST_SHIFT;
              if (state_q == ST_LOAD && req_q && !Smp_Ack) begin
                out_q  <= {out_q[FRAME_W-1 -: CHAN_W], {DATA_W{1'b1}}};
                late_q <= 1'b1;
                req_q  <= 1'b0;
              end
              if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                state_q <= ST_DONE;
                sdo_q   <= 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          sdo_q <= 1'b0;
          if (cs_rise) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b1;
            chan_q   <= chan_d;
            mode_q   <= mode_d;
            manual_q <= manual_d;
            pend_q   <= PEND_NONE;
            case (pend_q)
              PEND_MASK: mask_q <= cmd_q[NCHAN-1:0];
              PEND_THR:  thr_q  <= cmd_q[DATA_W-1:0];
              default: begin
                case (cmd_code)
                  CMD_AUTO1_PROG: pend_q <= PEND_MASK;
                  CMD_AUTO2_PROG: last_q <= cmd_q[9:6];
                  CMD_ALARM_PROG: pend_q <= PEND_THR;
                  CMD_GPIO: begin
                    gpio_q <= cmd_q[3:0];
                    if (cmd_q[9]) begin
                      mode_q   <= MODE_MANUAL;
                      manual_q <= '0;
                      chan_q   <= '0;
                      mask_q   <= MASK_RST;
                      last_q   <= LAST_RST;
                      thr_q    <= '1;
                    end
                  end
                  default: ;
                endcase
              end
            endcase
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SDO        = sdo_q;
  assign Smp_Req    = req_q;
  assign Smp_Chan   = smp_chan_q;
  assign Mode       = mode_q;
  assign GPIO_Out   = gpio_q;
  assign Frame_Done = done_q;
  assign Err_Late   = late_q;
  assign Alarm      = alarm_q & ALARM_EN;

endmodule

// File: tb/tb_ad_spi_responder.sv
// Directed bench for ad_spi_responder: a behavioural SPI master plus a sample source
// driving hand-computed frames, checked with immediate assertions.
module tb_ad_spi_responder;

`ifdef AD_RESP_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, SCLK, CS, SDI, Smp_Ack;
  logic [11:0] Smp_Data;
  logic        SDO, Smp_Req, Frame_Done, Err_Late, Alarm;
  logic [3:0]  Smp_Chan, GPIO_Out;
  logic [1:0]  Mode;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  ad_spi_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS(CS), .SDI(SDI), .SDO(SDO),
    .Smp_Req(Smp_Req), .Smp_Chan(Smp_Chan), .Smp_Ack(Smp_Ack), .Smp_Data(Smp_Data),
    .Mode(Mode), .GPIO_Out(GPIO_Out), .Frame_Done(Frame_Done),
    .Err_Late(Err_Late), .Alarm(Alarm)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (Frame_Done === 1'b1) fd_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One SPI transaction, SCLK = CLK/16; SDO is sampled just before each SCLK rise.
  task automatic frame(input logic [15:0] cmd, input bit ack, input logic [11:0] dat,
                       input int nbits, output logic [15:0] rx);
    int t;
    rx = '0;
    @(negedge CLK) CS = 1'b0;
    t = 0;
    while (Smp_Req !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("smp_req_raised", Smp_Req, 1'b1);
    if (ack) begin
      Smp_Ack  = 1'b1;
      Smp_Data = dat;
      @(negedge CLK);
      Smp_Ack  = 1'b0;
      Smp_Data = '0;
    end
    for (int i = 0; i < nbits; i++) begin
      SDI = (i < 16) ? cmd[15-i] : 1'b0;
      wait_clks(8);
      if (i < 16) rx[15-i] = SDO;
      SCLK = 1'b1;
      wait_clks(8);
      SCLK = 1'b0;
    end
    wait_clks(8);
    CS = 1'b1;
    wait_clks(8);
  endtask

  task automatic xfer(input string tag, input logic [15:0] cmd, input logic [11:0] dat,
                      input logic [15:0] exp, input logic [15:0] cmp_mask);
    logic [15:0] rx;
    int          fd0;
    fd0 = fd_cnt;
    frame(cmd, 1'b1, dat, 16, rx);
    check(tag, rx & cmp_mask, exp & cmp_mask);
    check({tag, "_frame_done"}, fd_cnt - fd0, 1);
  endtask

  initial begin
    logic [15:0] rx;
    logic [3:0]  auto1_ch[5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic [3:0]  auto2_ch[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    int          fd0;

    RST = 1'b1; CS = 1'b1; SCLK = 1'b0; SDI = 1'b0; Smp_Ack = 1'b0; Smp_Data = '0;
    wait_clks(4);
    RST = 1'b0;
    wait_clks(4);
    check("rst_sdo", SDO, 0);
    check("rst_req", Smp_Req, 0);
    check("rst_chan", Smp_Chan, 0);
    check("rst_mode", Mode, 0);
    check("rst_gpio", GPIO_Out, 0);
    check("rst_frame_done", fd_cnt, 0);
    check("rst_err_late", Err_Late, 0);
    check("rst_alarm", Alarm, 0);

    // Manual channel 0, then data 0x123 comes back on the following frame.
    xfer("f1_manual", 16'h1840, 12'h555, 16'h0555, 16'hFFFF);
    check("f1_req_dropped", Smp_Req, 0);
    xfer("f2_ret_0123", 16'h8000, 12'h123, 16'h0123, 16'hFFFF);
    check("f2_mode", Mode, 2'b00);
    xfer("f3_mask_word", 16'h000F, 12'h111, 16'h0111, 16'hFFFF);
    xfer("f4_auto1", 16'h2800, 12'h222, 16'h0222, 16'hFFFF);
    check("f4_mode", Mode, 2'b01);
    for (int i = 0; i < 5; i++)
      xfer("auto1_seq", 16'h0000, 12'h300 + 12'(i), {auto1_ch[i], 12'h300 + 12'(i)}, 16'hFFFF);

    // Auto2 with last channel 5.
    xfer("f10_auto2_prog", 16'h9140, 12'h444, 16'h0444, 16'h0FFF);
    xfer("f11_auto2", 16'h3800, 12'h455, 16'h0455, 16'h0FFF);
    check("f11_mode", Mode, 2'b10);
    for (int i = 0; i < 7; i++)
      xfer("auto2_seq", 16'h0000, 12'h500 + 12'(i), {auto2_ch[i], 12'h500 + 12'(i)}, 16'hFFFF);

    // Truncated frame after 9 SCLKs must be discarded.
    xfer("f19_manual0", 16'h1840, 12'h600, 16'h0600, 16'h0FFF);
    check("f19_mode", Mode, 2'b00);
    fd0 = fd_cnt;
    frame(16'h1980, 1'b1, 12'h601, 9, rx);
    check("trunc_no_frame_done", fd_cnt - fd0, 0);
    check("trunc_sdo_idle", SDO, 0);
    xfer("f21_after_trunc", 16'h1900, 12'h602, 16'h0602, 16'hFFFF);
    xfer("f22_manual2", 16'h0000, 12'h603, 16'h2603, 16'hFFFF);

    // GPIO write, then soft reset of the configuration.
    xfer("f23_gpio", 16'h4005, 12'h604, 16'h2604, 16'hFFFF);
    check("f23_gpio_out", GPIO_Out, 4'h5);
    xfer("f24_auto2", 16'h3800, 12'h605, 16'h2605, 16'hFFFF);
    check("f24_mode", Mode, 2'b10);
    xfer("f25_soft_rst", 16'h4203, 12'h606, 16'h0606, 16'hFFFF);
    check("f25_mode", Mode, 2'b00);
    xfer("f26_after_soft", 16'h0000, 12'h607, 16'h0607, 16'hFFFF);

    // Threshold 0x100: strictly-greater comparison.
    xfer("f27_alarm_prog", 16'hD000, 12'h000, 16'h0000, 16'hFFFF);
    xfer("f28_thr_word", 16'h0100, 12'h000, 16'h0000, 16'hFFFF);
    xfer("f29_over", 16'h0000, 12'h101, 16'h0101, 16'hFFFF);
    check("alarm_over_thr", Alarm, ALARM_ON);
    xfer("f30_equal", 16'h0000, 12'h100, 16'h0100, 16'hFFFF);
    check("alarm_at_thr", Alarm, 0);

    // Withheld ack: 0xFFF substituted and the sticky error set.
    check("late_before", Err_Late, 0);
    frame(16'h0000, 1'b0, 12'h000, 16, rx);
    check("late_data", rx, 16'h0FFF);
    check("late_flag", Err_Late, 1);
    check("late_req_dropped", Smp_Req, 0);
    xfer("f32_good", 16'h0000, 12'h777, 16'h0777, 16'hFFFF);
    check("late_sticky", Err_Late, 1);

    // Reset in the middle of a frame.
    fd0 = fd_cnt;
    @(negedge CLK) CS = 1'b0;
    wait_clks(6);
    check("midrst_req", Smp_Req, 1);
    for (int i = 0; i < 5; i++) begin
      SDI = 1'b1;
      wait_clks(8);
      SCLK = 1'b1;
      wait_clks(8);
      SCLK = 1'b0;
    end
    RST = 1'b1;
    wait_clks(2);
    check("midrst_sdo", SDO, 0);
    check("midrst_req_clear", Smp_Req, 0);
    check("midrst_err_late", Err_Late, 0);
    CS = 1'b1;
    SDI = 1'b0;
    wait_clks(4);
    RST = 1'b0;
    wait_clks(10);
    check("midrst_no_frame_done", fd_cnt - fd0, 0);
    xfer("after_midrst", 16'h0000, 12'h0AB, 16'h00AB, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
